// File: rtl/l1i_fetch_ctrl.sv
// L1 instruction cache fetch sequencer. It owns the fetch PC and sweeps the array to zero after reset.
// It also round-robins the single cache write port between the boot loader (A) and the refill engine (B).
module l1i_fetch_ctrl #(
    parameter int NUM_ENTRIES = 257,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 60
) (
    input  logic              clock_i,
    input  logic              reset,
    input  logic              reqA_valid_i,
    input  logic [ADDR_W-1:0] reqA_addr_i,
    input  logic [DATA_W-1:0] reqA_data_i,
    output logic              reqA_ready_o,
    input  logic              reqB_valid_i,
    input  logic [ADDR_W-1:0] reqB_addr_i,
    input  logic [DATA_W-1:0] reqB_data_i,
    output logic              reqB_ready_o,
    input  logic              halt_i,
    input  logic              branch_valid_i,
    input  logic [ADDR_W-1:0] branch_offset_i,
    input  logic              branch_dir_i,
    output logic              cache_we_o,
    output logic [ADDR_W-1:0] cache_waddr_o,
    output logic [DATA_W-1:0] cache_wdata_o,
    output logic [ADDR_W-1:0] fetch_pc_o,
    output logic              fetch_en_o,
    output logic              err_o,
    output logic [1:0]        state_o
);

    localparam int CNT_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        FILL  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  clr_cnt;
    logic              clr_last;
    logic              prefer_a;
    logic              grant_a;
    logic              grant_b;
    logic              grant_any;
    logic              gnt_in_range;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_next = state;
        gnt_addr   = reqA_addr_i;
        gnt_data   = reqA_data_i;
        clr_last   = (clr_cnt == CNT_W'(NUM_ENTRIES - 1));
        if (state == CLEAR) begin
            state_next = clr_last ? RUN : CLEAR;
        end else begin
            // prefer_a is cleared by an A grant, so a tie goes to whoever waited
            grant_a = reqA_valid_i && (!reqB_valid_i || prefer_a);
            grant_b = reqB_valid_i && !grant_a;
            if (grant_b) begin
                gnt_addr = reqB_addr_i;
                gnt_data = reqB_data_i;
            end
            if (grant_a || grant_b) begin
                state_next = FILL;
            end else if (halt_i) begin
                state_next = HALT;
            end else begin
                state_next = RUN;
            end
        end
    end

    assign grant_any    = grant_a || grant_b;
    assign gnt_in_range = (gnt_addr < ADDR_W'(NUM_ENTRIES));
    assign reqA_ready_o = grant_a;
    assign reqB_ready_o = grant_b;
    assign state_o      = state;

    always_ff @(posedge clock_i) begin
        if (!reset) begin
            state         <= CLEAR;
            clr_cnt       <= '0;
            prefer_a      <= 1'b1;
            cache_we_o    <= 1'b0;
            cache_waddr_o <= '0;
            cache_wdata_o <= '0;
            fetch_pc_o    <= '0;
            fetch_en_o    <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_en_o <= (state_next == RUN);
            cache_we_o <= 1'b0;
            err_o      <= 1'b0;
            if (state == CLEAR) begin
                cache_we_o    <= 1'b1;
                cache_waddr_o <= ADDR_W'(clr_cnt);
                cache_wdata_o <= '0;
                clr_cnt       <= clr_last ? '0 : clr_cnt + 1'b1;
            end else begin
                if (grant_any) begin
                    prefer_a <= grant_b;
                    // out-of-range fills still handshake but never reach the array
                    if (gnt_in_range) begin
                        cache_we_o    <= 1'b1;
                        cache_waddr_o <= gnt_addr;
                        cache_wdata_o <= gnt_data;
                    end else begin
                        err_o <= 1'b1;
                    end
                end
                if (branch_valid_i) begin
                    fetch_pc_o <= branch_dir_i ? fetch_pc_o + branch_offset_i
                                               : fetch_pc_o - branch_offset_i;
                end else if (fetch_en_o) begin
                    fetch_pc_o <= fetch_pc_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l1i_fetch_ctrl.sv
// Directed bench for l1i_fetch_ctrl: clear sweep, PC arithmetic, round-robin fills,
// out-of-range drop, halt with redirect and reset during a grant.
module tb_l1i_fetch_ctrl;
    localparam int NUM_ENTRIES = 257;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 60;

    logic              clock_i = 1'b0;
    logic              reset = 1'b0;
    logic              reqA_valid_i = 1'b0;
    logic [ADDR_W-1:0] reqA_addr_i = '0;
    logic [DATA_W-1:0] reqA_data_i = '0;
    logic              reqA_ready_o;
    logic              reqB_valid_i = 1'b0;
    logic [ADDR_W-1:0] reqB_addr_i = '0;
    logic [DATA_W-1:0] reqB_data_i = '0;
    logic              reqB_ready_o;
    logic              halt_i = 1'b0;
    logic              branch_valid_i = 1'b0;
    logic [ADDR_W-1:0] branch_offset_i = '0;
    logic              branch_dir_i = 1'b0;
    logic              cache_we_o;
    logic [ADDR_W-1:0] cache_waddr_o;
    logic [DATA_W-1:0] cache_wdata_o;
    logic [ADDR_W-1:0] fetch_pc_o;
    logic              fetch_en_o;
    logic              err_o;
    logic [1:0]        state_o;

    int total = 0;
    int bad   = 0;

    l1i_fetch_ctrl #(.NUM_ENTRIES(NUM_ENTRIES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock_i(clock_i), .reset(reset),
        .reqA_valid_i(reqA_valid_i), .reqA_addr_i(reqA_addr_i), .reqA_data_i(reqA_data_i),
        .reqA_ready_o(reqA_ready_o),
        .reqB_valid_i(reqB_valid_i), .reqB_addr_i(reqB_addr_i), .reqB_data_i(reqB_data_i),
        .reqB_ready_o(reqB_ready_o),
        .halt_i(halt_i), .branch_valid_i(branch_valid_i), .branch_offset_i(branch_offset_i),
        .branch_dir_i(branch_dir_i),
        .cache_we_o(cache_we_o), .cache_waddr_o(cache_waddr_o), .cache_wdata_o(cache_wdata_o),
        .fetch_pc_o(fetch_pc_o), .fetch_en_o(fetch_en_o), .err_o(err_o), .state_o(state_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic branch(input logic dir, input logic [ADDR_W-1:0] off);
        branch_valid_i  = 1'b1;
        branch_dir_i    = dir;
        branch_offset_i = off;
        tick();
        branch_valid_i  = 1'b0;
    endtask

    initial begin
        // reset held for two cycles
        tick();
        tick();
        check("rst_we", cache_we_o, 0);
        check("rst_waddr", cache_waddr_o, 0);
        check("rst_wdata", cache_wdata_o, 0);
        check("rst_pc", fetch_pc_o, 0);
        check("rst_en", fetch_en_o, 0);
        check("rst_err", err_o, 0);
        check("rst_state", state_o, 0);
        reset = 1'b1;

        // clear sweep; requests and branches during the sweep must be ignored
        reqA_valid_i    = 1'b1;
        reqA_addr_i     = 16'h0005;
        branch_valid_i  = 1'b1;
        branch_dir_i    = 1'b1;
        branch_offset_i = 16'h0007;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (i < 200) begin
                check("clr_readyA", reqA_ready_o, 0);
            end else begin
                reqA_valid_i   = 1'b0;
                branch_valid_i = 1'b0;
            end
            tick();
            check("clr_we", cache_we_o, 1);
            check("clr_addr", cache_waddr_o, i);
            check("clr_data", cache_wdata_o, 0);
            check("clr_state", state_o, (i == NUM_ENTRIES - 1) ? 1 : 0);
            check("clr_en", fetch_en_o, (i == NUM_ENTRIES - 1) ? 1 : 0);
        end
        check("run_pc0", fetch_pc_o, 16'h0000);
        tick(); check("run_pc1", fetch_pc_o, 16'h0001);
        tick(); check("run_pc2", fetch_pc_o, 16'h0002);
        check("run_we_idle", cache_we_o, 0);
        tick(); check("run_pc3", fetch_pc_o, 16'h0003);
        check("run_en", fetch_en_o, 1);

        // PC arithmetic
        branch(1'b1, 16'h000D); check("br_fwd_10", fetch_pc_o, 16'h0010);
        branch(1'b0, 16'h0005); check("br_bwd_0b", fetch_pc_o, 16'h000B);
        check("br_en", fetch_en_o, 1);
        tick();                 check("seq_0c", fetch_pc_o, 16'h000C);
        branch(1'b1, 16'h0014); check("br_fwd_20", fetch_pc_o, 16'h0020);
        branch(1'b1, 16'hFFF0); check("br_wrap_10", fetch_pc_o, 16'h0010);
        branch(1'b1, 16'hFFEF); check("br_ffff", fetch_pc_o, 16'hFFFF);
        tick();                 check("seq_wrap_0", fetch_pc_o, 16'h0000);
        tick();                 check("seq_1", fetch_pc_o, 16'h0001);

        // single A fill makes A the most recent grant
        reqA_valid_i = 1'b1;
        reqA_addr_i  = 16'h0010;
        reqA_data_i  = 60'h0A5;
        #1;
        check("a1_readyA", reqA_ready_o, 1);
        check("a1_readyB", reqB_ready_o, 0);
        tick();
        reqA_valid_i = 1'b0;
        check("a1_we", cache_we_o, 1);
        check("a1_addr", cache_waddr_o, 16'h0010);
        check("a1_data", cache_wdata_o, 60'h0A5);
        check("a1_state", state_o, 2);
        check("a1_en", fetch_en_o, 0);
        check("a1_pc", fetch_pc_o, 16'h0002);
        tick();
        check("a1_resume_state", state_o, 1);
        check("a1_resume_en", fetch_en_o, 1);
        check("a1_resume_pc", fetch_pc_o, 16'h0002);
        check("a1_resume_we", cache_we_o, 0);

        // contention: expect B,A,B,A with PC frozen at 3
        for (int i = 0; i < 4; i++) begin
            reqA_valid_i = 1'b1;
            reqB_valid_i = 1'b1;
            reqA_addr_i  = 16'(16'h0020 + i);
            reqB_addr_i  = 16'(16'h0030 + i);
            reqA_data_i  = 60'(60'h100 + i);
            reqB_data_i  = 60'(60'h200 + i);
            #1;
            check("rr_readyA", reqA_ready_o, (i % 2 == 1) ? 1 : 0);
            check("rr_readyB", reqB_ready_o, (i % 2 == 0) ? 1 : 0);
            tick();
            check("rr_we", cache_we_o, 1);
            check("rr_addr", cache_waddr_o, (i % 2 == 0) ? 16'h0030 + i : 16'h0020 + i);
            check("rr_data", cache_wdata_o, (i % 2 == 0) ? 60'h200 + i : 60'h100 + i);
            check("rr_en", fetch_en_o, 0);
            check("rr_pc", fetch_pc_o, 16'h0003);
            check("rr_state", state_o, 2);
        end
        reqA_valid_i = 1'b0;
        reqB_valid_i = 1'b0;
        tick();
        check("rr_resume_state", state_o, 1);
        check("rr_resume_en", fetch_en_o, 1);
        check("rr_resume_pc", fetch_pc_o, 16'h0003);
        check("rr_resume_we", cache_we_o, 0);

        // out-of-range refill is acknowledged and dropped
        reqB_valid_i = 1'b1;
        reqB_addr_i  = 16'h0101;
        reqB_data_i  = 60'h777;
        #1;
        check("oor_readyB", reqB_ready_o, 1);
        check("oor_readyA", reqA_ready_o, 0);
        tick();
        reqB_valid_i = 1'b0;
        check("oor_we", cache_we_o, 0);
        check("oor_err", err_o, 1);
        check("oor_state", state_o, 2);
        check("oor_pc", fetch_pc_o, 16'h0004);
        tick();
        check("oor_err_clr", err_o, 0);
        check("oor_we2", cache_we_o, 0);
        check("oor_resume_en", fetch_en_o, 1);
        check("oor_resume_pc", fetch_pc_o, 16'h0004);

        // halt with fill and redirect
        branch(1'b1, 16'h003B); check("h_pre_pc", fetch_pc_o, 16'h003F);
        halt_i = 1'b1;
        tick();
        check("h_en", fetch_en_o, 0);
        check("h_state", state_o, 3);
        check("h_pc", fetch_pc_o, 16'h0040);
        tick();
        check("h_pc_hold", fetch_pc_o, 16'h0040);
        check("h_en_hold", fetch_en_o, 0);
        reqA_valid_i = 1'b1;
        reqA_addr_i  = 16'h0055;
        reqA_data_i  = 60'h0FEDCBA987654321;
        #1;
        check("h_readyA", reqA_ready_o, 1);
        tick();
        reqA_valid_i = 1'b0;
        check("h_fill_we", cache_we_o, 1);
        check("h_fill_addr", cache_waddr_o, 16'h0055);
        check("h_fill_data", cache_wdata_o, 60'h0FEDCBA987654321);
        check("h_fill_state", state_o, 2);
        check("h_fill_pc", fetch_pc_o, 16'h0040);
        tick();
        check("h_back_state", state_o, 3);
        check("h_back_we", cache_we_o, 0);
        branch(1'b1, 16'h0004);
        check("h_br_pc", fetch_pc_o, 16'h0044);
        check("h_br_en", fetch_en_o, 0);
        halt_i = 1'b0;
        tick();
        check("h_resume_state", state_o, 1);
        check("h_resume_en", fetch_en_o, 1);
        check("h_resume_pc", fetch_pc_o, 16'h0044);
        tick();
        check("h_seq_pc", fetch_pc_o, 16'h0045);

        // reset in the same cycle as a grant
        reqA_valid_i = 1'b1;
        reqA_addr_i  = 16'h0066;
        reqA_data_i  = 60'h0BEEF;
        reset        = 1'b0;
        tick();
        reqA_valid_i = 1'b0;
        check("r6_we", cache_we_o, 0);
        check("r6_addr", cache_waddr_o, 0);
        check("r6_data", cache_wdata_o, 0);
        check("r6_pc", fetch_pc_o, 0);
        check("r6_en", fetch_en_o, 0);
        check("r6_err", err_o, 0);
        check("r6_state", state_o, 0);
        reset = 1'b1;
        tick();
        check("r6_clr_we", cache_we_o, 1);
        check("r6_clr_addr", cache_waddr_o, 0);
        check("r6_clr_data", cache_wdata_o, 0);
        check("r6_clr_state", state_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l1i_fetch_ctrl.md
Name: l1i_fetch_ctrl

Overview:
Sequencer and arbiter for the L1 instruction cache. It owns the fetch PC, including sequential increment, branch redirect and halt. It shares the single cache write port between two fill requesters, the boot loader (A) and the memory refill engine (B), using round-robin arbitration. After reset it sweeps the cache array to zero before any fetch is issued.

Parameters:
NUM_ENTRIES, 257, number of cache lines; valid write addresses are 0..NUM_ENTRIES-1
ADDR_W, 16, PC and cache address width
DATA_W, 60, cache line / instruction width

Ports:
clock_i  in  1  clock; all state updates on posedge clock_i
reset  in  1  reset, synchronous, active-low
reqA_valid_i  in  1  loader fill request
reqA_addr_i  in  ADDR_W  loader write address
reqA_data_i  in  DATA_W  loader write data
reqA_ready_o  out  1  loader grant (combinational)
reqB_valid_i  in  1  refill request
reqB_addr_i  in  ADDR_W  refill write address
reqB_data_i  in  DATA_W  refill write data
reqB_ready_o  out  1  refill grant (combinational)
halt_i  in  1  freeze fetch while high
branch_valid_i  in  1  apply branch redirect this cycle
branch_offset_i  in  ADDR_W  unsigned branch offset
branch_dir_i  in  1  1 = forward (PC + offset), 0 = backward (PC - offset)
cache_we_o  out  1  cache write enable
cache_waddr_o  out  ADDR_W  cache write address
cache_wdata_o  out  DATA_W  cache write data
fetch_pc_o  out  ADDR_W  fetch address presented to the cache
fetch_en_o  out  1  fetch_pc_o is valid and issued this cycle
err_o  out  1  one-cycle pulse: an out-of-range fill address was dropped
state_o  out  2  current state: CLEAR=0, RUN=1, FILL=2, HALT=3

Behaviour:
- Reset (reset==0 at posedge):
  - state <= CLEAR, clear counter <= 0, round-robin pointer <= "A preferred".
  - All registered outputs <= 0: cache_we_o, cache_waddr_o, cache_wdata_o, fetch_pc_o, fetch_en_o, err_o.
  - Reset overrides every other event. A grant accepted in the same cycle is discarded.
- CLEAR:
  - Each cycle writes cache_we_o=1, cache_waddr_o=counter, cache_wdata_o=0; counter increments.
  - After address NUM_ENTRIES-1 is written, next state is RUN. The sweep takes exactly NUM_ENTRIES cycles.
  - In CLEAR: both ready outputs are 0, branches are ignored, halt_i is ignored, fetch_en_o=0.
- Arbitration (RUN, FILL, HALT):
  - readyX = validX AND grant selection. At most one ready per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester not granted most recently. The pointer updates on every grant.
- Write path:
  - A grant at posedge N produces cache_we_o=1 with the granted address/data during cycle N+1 (registered, latency 1).
  - No grant: cache_we_o <= 0.
  - Granted address >= NUM_ENTRIES: handshake still completes, cache_we_o stays 0, err_o=1 for one cycle.
- State transitions, evaluated each posedge outside CLEAR, in priority order:
  - any grant -> FILL
  - else halt_i=1 -> HALT
  - else -> RUN
- Fetch enable and PC:
  - fetch_en_o <= (next state == RUN). Fetch is therefore stalled during fills and during halt.
  - PC update priority: branch_valid_i=1 -> fetch_pc_o <= fetch_pc_o ± branch_offset_i, modulo 2^ADDR_W. This applies in RUN, FILL and HALT.
  - Else if fetch_en_o=1 -> fetch_pc_o + 1, wrapping 0xFFFF -> 0x0000.
  - Else hold.
  - A branch while stalled therefore redirects the resume point; no fetch is lost or duplicated.
- Range checks: fetch_pc_o is not range-checked against NUM_ENTRIES. That check belongs to the cache.

Test Plan:
1. Hold reset=0 for 2 cycles, then release -> cache_we_o=1 for 257 cycles with addr 0..256 and data 0; state_o moves 0->1; fetch_en_o=1 with fetch_pc_o 0,1,2,3 on consecutive cycles.
2. Backward branch at fetch_pc_o=0x0010, dir=0, offset=5 -> next fetch_pc_o=0x000B. Forward branch at 0x0020, dir=1, offset=0xFFF0 -> 0x0010 (wrap). Sequential at 0xFFFF -> 0x0000.
3. A and B both valid for 4 cycles, last grant was A -> grants B,A,B,A. cache_we_o addresses follow one cycle later; fetch_en_o=0 and fetch_pc_o frozen throughout; fetch resumes at the same PC one cycle after the valids drop.
4. Single B request with addr 0x0101 -> reqB_ready_o=1, cache_we_o stays 0, err_o=1 for exactly one cycle.
5. halt_i=1 at fetch_pc_o=0x0040 -> fetch_en_o=0 next cycle and PC holds. An A fill during halt is written. A branch during halt with dir=1, offset=4 -> resume at 0x0044 after halt_i=0.
6. Assert reset during a FILL grant cycle -> next cycle all outputs are 0, state_o=CLEAR, and the pending write never appears on cache_we_o.
